// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RISC-V sequencer: states, opcodes,
// and ALU operand/operation selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore sequencer for a multicycle RISC-V datapath sharing one memory port.
// Outputs decode from the current state (plus memReady/zero where a strobe
// must only fire on the completing cycle); state and instret are registered.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             haltReq,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcSrc,
    output logic             iOrD,
    output logic             irWrite,
    output logic             memRead,
    output logic             memWrite,
    output logic             regWrite,
    output logic             memToReg,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic             busy,
    output logic             trap,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             boundary;

    // State and retired-instruction counter; reset aborts any pending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and control-output decode.
    always_comb begin
        state_d  = state_q;
        boundary = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = 1'b0;
        iOrD     = 1'b0;
        irWrite  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        regWrite = 1'b0;
        memToReg = 1'b0;
        aluSrcA  = SRCA_PC;
        aluSrcB  = SRCB_RS2;
        aluOp    = ALUOP_ADD;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed
                // together with the IR on the completing cycle.
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute the branch target from the old PC.
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                aluOp   = ALUOP_FUNCT;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                regWrite = 1'b1;
                boundary = 1'b1;
            end
            S_MEM_ADDR: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_IMM;
                state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                memRead = 1'b1;
                iOrD    = 1'b1;
                if (memReady) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
                boundary = 1'b1;
            end
            S_MEM_WR: begin
                memWrite = 1'b1;
                iOrD     = 1'b1;
                boundary = memReady;
            end
            S_BRANCH: begin
                aluSrcA = SRCA_RS1;
                aluSrcB = SRCB_RS2;
                aluOp   = ALUOP_SUB;
                pcSrc   = 1'b1;
                pcWrite = zero;
                boundary = 1'b1;
            end
            S_TRAP: begin
                // Sticky until reset; start is deliberately ignored.
                state_d = S_TRAP;
            end
            default: state_d = S_IDLE;
        endcase
        if (boundary) state_d = haltReq ? S_IDLE : S_FETCH;
    end

    assign instret_d = boundary ? instret_q + CNT_W'(1) : instret_q;
    assign instret   = instret_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_TRAP);
    assign trap      = (state_q == S_TRAP);

endmodule
